spi_sclk_gen: RTL and testbench

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

---
 rtl/spi_sclk_gen.sv | 205 ++++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// spi_sclk_gen : SPI SCLK, sample/shift strobe and frame-timing generator.
// Optional chip-select framing (cs_n, SETUP/HOLD) under macro SPI_SCLK_CS_EN.
// Revision 1.0
// ============================================================================
module spi_sclk_gen #(
   parameter int DIV_W = 16,
   parameter int BIT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIV_W-1:0] div,
   input  logic [BIT_W-1:0] nbits,
   input  logic             cpol,
   input  logic             cpha,
   output logic             sclk,
   output logic             sample_en,
   output logic             shift_en,
   output logic             busy,
   output logic             done
`ifdef SPI_SCLK_CS_EN
   ,
   output logic             cs_n
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_FIN   = 3'd2
`ifdef SPI_SCLK_CS_EN
      ,
      S_SETUP = 3'd3,
      S_HOLD  = 3'd4
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [BIT_W:0]   edge_q, edge_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] nbits_q, nbits_d;
   logic             cpol_q, cpol_d;
   logic             cpha_q, cpha_d;
   logic             sclk_q, sclk_d;
   logic             sample_en_q, sample_en_d;
   logic             shift_en_q, shift_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef SPI_SCLK_CS_EN
   logic             cs_n_q, cs_n_d;
`endif

   logic [BIT_W:0]   w_total;
   logic [BIT_W:0]   w_edge_nxt;
   logic [DIV_W-1:0] w_cnt_inc;
   logic             w_cnt_wrap;

   assign w_total    = {nbits_q, 1'b0};
   assign w_edge_nxt = edge_q + (BIT_W+1)'(1);
   assign w_cnt_inc  = cnt_q + DIV_W'(1);
   assign w_cnt_wrap = (cnt_q == div_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      edge_d      = edge_q;
      div_d       = div_q;
      nbits_d     = nbits_q;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      sclk_d      = sclk_q;
      sample_en_d = 1'b0;
      shift_en_d  = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef SPI_SCLK_CS_EN
      cs_n_d      = cs_n_q;
`endif
      case (state_q)
         S_IDLE: begin
            sclk_d = cpol;
            cnt_d  = '0;
            edge_d = '0;
            busy_d = 1'b0;
            if (start && (nbits != '0)) begin
               div_d   = div;
               nbits_d = nbits;
               cpol_d  = cpol;
               cpha_d  = cpha;
               busy_d  = 1'b1;
`ifdef SPI_SCLK_CS_EN
               cs_n_d  = 1'b0;
               state_d = S_SETUP;
`else
               state_d = S_RUN;
`endif
            end
         end
`ifdef SPI_SCLK_CS_EN
         S_SETUP: begin
            if (w_cnt_wrap) begin
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               cnt_d = w_cnt_inc;
            end
         end
         S_HOLD: begin
            if (w_cnt_wrap) begin
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               cnt_d = w_cnt_inc;
            end
         end
`endif
         S_RUN: begin
            // The cycle showing the final edge is spent here; the exit follows it.
            if (edge_q == w_total) begin
               cnt_d = '0;
`ifdef SPI_SCLK_CS_EN
               state_d = S_HOLD;
`else
               done_d  = 1'b1;
               state_d = S_FIN;
`endif
            end else if (w_cnt_wrap) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               edge_d = w_edge_nxt;
               if (!edge_q[0]) begin
                  sample_en_d = ~cpha_q;
                  shift_en_d  = cpha_q;
               end else begin
                  sample_en_d = cpha_q;
                  shift_en_d  = ~cpha_q & (w_edge_nxt != w_total);
               end
            end else begin
               cnt_d = w_cnt_inc;
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            edge_d  = '0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         edge_q      <= '0;
         div_q       <= '0;
         nbits_q     <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         sclk_q      <= 1'b0;
         sample_en_q <= 1'b0;
         shift_en_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SPI_SCLK_CS_EN
         cs_n_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         edge_q      <= edge_d;
         div_q       <= div_d;
         nbits_q     <= nbits_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         sclk_q      <= sclk_d;
         sample_en_q <= sample_en_d;
         shift_en_q  <= shift_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef SPI_SCLK_CS_EN
         cs_n_q      <= cs_n_d;
`endif
      end
   end

   assign sclk      = sclk_q;
   assign sample_en = sample_en_q;
   assign shift_en  = shift_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef SPI_SCLK_CS_EN
   assign cs_n      = cs_n_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// tb_spi_sclk_gen : self-checking bench for spi_sclk_gen (SPI_SCLK_CS_EN aware).
// Revision 1.0
// ============================================================================
module tb_spi_sclk_gen;
   localparam int DIV_W = 16;
   localparam int BIT_W = 6;
`ifdef SPI_SCLK_CS_EN
   localparam bit CS_ON = 1'b1;
`else
   localparam bit CS_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [DIV_W-1:0] div = '0;
   logic [BIT_W-1:0] nbits = BIT_W'(1);
   logic             cpol = 1'b0;
   logic             cpha = 1'b0;
   logic             sclk, sample_en, shift_en, busy, done;
`ifdef SPI_SCLK_CS_EN
   logic             cs_n;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   spi_sclk_gen #(.DIV_W(DIV_W), .BIT_W(BIT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .div       (div),
      .nbits     (nbits),
      .cpol      (cpol),
      .cpha      (cpha),
      .sclk      (sclk),
      .sample_en (sample_en),
      .shift_en  (shift_en),
      .busy      (busy),
      .done      (done)
`ifdef SPI_SCLK_CS_EN
      ,
      .cs_n      (cs_n)
`endif
   );

   task automatic check_b(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Frame model: t counts cycles since the acceptance cycle (t=1 is the first busy cycle).
   bit   m_act = 1'b0;
   int   m_t = 0, m_div = 0, m_n = 0, m_done_t = 0;
   logic m_cpol = 1'b0, m_cpha = 1'b0, m_idle = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_act  <= 1'b0;
         m_idle <= 1'b0;
      end else if (m_act) begin
         if (m_t == m_done_t) begin
            m_act  <= 1'b0;
            m_idle <= m_cpol;
         end else begin
            m_t <= m_t + 1;
         end
      end else begin
         m_idle <= cpol;
         if (start && nbits != '0) begin
            m_act    <= 1'b1;
            m_t      <= 1;
            m_div    <= int'(div);
            m_n      <= int'(nbits);
            m_cpol   <= cpol;
            m_cpha   <= cpha;
            m_done_t <= (int'(div) + 1) * 2 * int'(nbits) + 2 + (CS_ON ? 2 * (int'(div) + 1) : 0);
         end
      end
   end

   // sel: 0 sclk, 1 sample_en, 2 shift_en, 3 busy, 4 done, 5 cs_n
   function automatic logic exp_bit(input int sel);
      int h, pre, tot, r, k;
      logic [5:0] v;
      v = {1'b1, 4'b0000, m_idle};
      if (m_act) begin
         h    = m_div + 1;
         pre  = CS_ON ? h : 0;
         tot  = 2 * m_n;
         v[3] = 1'b1;
         v[4] = (m_t == m_done_t);
         v[5] = (m_t == m_done_t);
         v[0] = m_cpol;
         if (m_t > pre) begin
            r = m_t - 1 - pre;
            k = r / h;
            if (r % h == 0 && k >= 1 && k <= tot) begin
               if (k[0]) begin
                  v[1] = ~m_cpha;
                  v[2] = m_cpha;
               end else begin
                  v[1] = m_cpha;
                  v[2] = ~m_cpha & (k != tot);
               end
            end
            if (k > tot) k = tot;
            v[0] = m_cpol ^ k[0];
         end
      end
      return v[sel];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check_b("mdl_sclk", sclk, exp_bit(0));
         check_b("mdl_sample_en", sample_en, exp_bit(1));
         check_b("mdl_shift_en", shift_en, exp_bit(2));
         check_b("mdl_busy", busy, exp_bit(3));
         check_b("mdl_done", done, exp_bit(4));
`ifdef SPI_SCLK_CS_EN
         check_b("mdl_cs_n", cs_n, exp_bit(5));
`endif
      end
   end

   function automatic int ex(input int d);
      return CS_ON ? 2 * (d + 1) : 0;
   endfunction

   // Runs one frame, scrambling the inputs right after acceptance; optional start poke at t=poke.
   task automatic frame(input int d, input int n, input logic p, input logic h, input int poke,
                        output int t_done, output int ne, output int ns, output int nsh,
                        output logic last);
      logic prev;
      int   t;
      repeat (2) @(negedge clk);
      div = DIV_W'(d); nbits = BIT_W'(n); cpol = p; cpha = h; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      div = DIV_W'(d + 3); nbits = BIT_W'(n + 5); cpol = ~p; cpha = ~h;
      t = 1; prev = sclk; ne = 0; ns = 0; nsh = 0;
      while (done !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
         start = (t == poke);
         if (sclk !== prev) ne++;
         prev = sclk;
         if (sample_en === 1'b1) ns++;
         if (shift_en === 1'b1) nsh++;
      end
      start  = 1'b0;
      t_done = t;
      last   = sclk;
   endtask

   int   td, ne, ns, nsh, cnt_a, cnt_b, p1, d1;
   logic ls;
   logic s_sc[0:39], s_sa[0:39], s_sh[0:39], s_dn[0:39], s_bz[0:39];

   initial begin
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check_b("rst_sclk", sclk, 1'b0);
      check_b("rst_busy", busy, 1'b0);
      check_b("rst_done", done, 1'b0);
      check_b("rst_sample", sample_en, 1'b0);
      check_b("rst_shift", shift_en, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      frame(1, 8, 1'b0, 1'b0, 0, td, ne, ns, nsh, ls);
      check_i("f1_done_cycle", td, 34 + ex(1));
      check_i("f1_edges", ne, 16);
      check_i("f1_samples", ns, 8);
      check_i("f1_shifts", nsh, 7);
      check_b("f1_last_sclk", ls, 1'b0);

      frame(2, 3, 1'b1, 1'b0, 0, td, ne, ns, nsh, ls);
      check_i("f2_done_cycle", td, 20 + ex(2));
      check_i("f2_edges", ne, 6);
      check_i("f2_samples", ns, 3);
      check_i("f2_shifts", nsh, 2);
      check_b("f2_last_sclk", ls, 1'b1);

      frame(0, 5, 1'b0, 1'b1, 0, td, ne, ns, nsh, ls);
      check_i("f3_done_cycle", td, 12 + ex(0));
      check_i("f3_edges", ne, 10);
      check_i("f3_samples", ns, 5);
      check_i("f3_shifts", nsh, 5);

      frame(3, 2, 1'b1, 1'b1, 6, td, ne, ns, nsh, ls);
      check_i("poke_done_cycle", td, 18 + ex(3));
      check_i("poke_edges", ne, 4);
      check_i("poke_samples", ns, 2);
      check_i("poke_shifts", nsh, 2);
      check_b("poke_last_sclk", ls, 1'b1);
      cnt_a = 0;
      repeat (6) @(negedge clk) if (busy === 1'b1) cnt_a++;
      check_i("poke_no_restart", cnt_a, 0);

      // Single-bit frame at full speed
      p1 = CS_ON ? 1 : 0;
      repeat (2) @(negedge clk);
      div = '0; nbits = BIT_W'(1); cpol = 1'b1; cpha = 1'b1; start = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         @(negedge clk);
         start = 1'b0;
         s_sc[t] = sclk; s_sa[t] = sample_en; s_sh[t] = shift_en; s_dn[t] = done;
      end
      check_b("one_sclk_a", s_sc[1 + p1], 1'b1);
      check_b("one_sclk_b", s_sc[2 + p1], 1'b0);
      check_b("one_sclk_c", s_sc[3 + p1], 1'b1);
      check_b("one_shift", s_sh[2 + p1], 1'b1);
      check_b("one_no_sample", s_sa[2 + p1], 1'b0);
      check_b("one_sample", s_sa[3 + p1], 1'b1);
      check_b("one_done", s_dn[4 + ex(0)], 1'b1);

      // Zero-length request
      repeat (2) @(negedge clk);
      nbits = '0; div = '0; start = 1'b1; cnt_a = 0; cnt_b = 0;
      for (int t = 1; t <= 8; t++) begin
         @(negedge clk);
         if (t == 5) start = 1'b0;
         if (busy === 1'b1) cnt_a++;
         if (sample_en === 1'b1 || shift_en === 1'b1 || done === 1'b1) cnt_b++;
      end
      check_i("nb0_busy", cnt_a, 0);
      check_i("nb0_pulses", cnt_b, 0);

      // Reset landing on the clock edge that would make edge 5
      p1 = CS_ON ? 2 : 0;
      repeat (2) @(negedge clk);
      div = DIV_W'(1); nbits = BIT_W'(4); cpol = 1'b0; cpha = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9 + p1) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_b("abort_sclk", sclk, 1'b0);
      check_b("abort_sample", sample_en, 1'b0);
      check_b("abort_shift", shift_en, 1'b0);
      check_b("abort_busy", busy, 1'b0);
      check_b("abort_done", done, 1'b0);
      cnt_a = 0;
      repeat (20) @(negedge clk) if (done === 1'b1) cnt_a++;
      check_i("abort_no_done", cnt_a, 0);
      frame(1, 4, 1'b0, 1'b0, 0, td, ne, ns, nsh, ls);
      check_i("after_abort_done_cycle", td, 18 + ex(1));
      check_i("after_abort_edges", ne, 8);

      // Back-to-back frames with start held
      d1 = 6 + ex(0);
      repeat (2) @(negedge clk);
      div = '0; nbits = BIT_W'(2); cpol = 1'b1; cpha = 1'b0; start = 1'b1;
      cnt_a = 0;
      for (int t = 1; t <= 2 * d1 + 2; t++) begin
         @(negedge clk);
         if (t == d1 + 2) start = 1'b0;
         s_sc[t] = sclk; s_bz[t] = busy; s_dn[t] = done;
         if (t > 1 && s_sc[t] !== s_sc[t-1]) cnt_a++;
      end
      check_b("b2b_done1", s_dn[d1], 1'b1);
      check_b("b2b_gap_busy", s_bz[d1 + 1], 1'b0);
      check_b("b2b_busy2", s_bz[d1 + 2], 1'b1);
      check_b("b2b_done2", s_dn[2 * d1 + 1], 1'b1);
      check_b("b2b_sclk_gap_a", s_sc[d1 + 1], 1'b1);
      check_b("b2b_sclk_gap_b", s_sc[d1 + 2], 1'b1);
      check_i("b2b_edges", cnt_a, 8);

`ifdef SPI_SCLK_CS_EN
      // Chip-select framing, div=2 nbits=4
      repeat (2) @(negedge clk);
      div = DIV_W'(2); nbits = BIT_W'(4); cpol = 1'b0; cpha = 1'b0; start = 1'b1;
      check_b("cs_idle_high", cs_n, 1'b1);
      cnt_a = 0; cnt_b = 0;
      for (int t = 1; t <= 34; t++) begin
         @(negedge clk);
         start = 1'b0;
         if (t == 1) check_b("cs_fall", cs_n, 1'b0);
         if (t == 6) check_b("cs_pre_edge", sclk, 1'b0);
         if (t == 7) check_b("cs_first_edge", sclk, 1'b1);
         if (t == 31) check_b("cs_hold_low", cs_n, 1'b0);
         if (t == 32) begin
            check_b("cs_rise", cs_n, 1'b1);
            check_b("cs_done", done, 1'b1);
         end
      end
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
